alu_reservation_station: RTL and testbench



---
 rtl/alu_reservation_station.sv | 142 ++++++++++++++
 tb/tb_alu_reservation_station.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: oldest-ready-first ALU issue buffer with writeback wakeup; ALU_RS_BYPASS_EN adds dispatch->issue bypass.
// Latency: dispatch->issue 1 cycle (0 with ALU_RS_BYPASS_EN), wakeup->issue 1 cycle.
// Backpressure: dispatch_ready low while full; the selected entry is held until issue_ready.
module alu_reservation_station #(
  parameter int RS_DEPTH     = 4,
  parameter int WAKEUP_PORTS = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      dispatch_valid,
  input  logic [47:0]               dispatch_struct,
  output logic                      dispatch_ready,
  input  logic [WAKEUP_PORTS-1:0]   wakeup_valid,
  input  logic [6*WAKEUP_PORTS-1:0] wakeup_tag,
  output logic                      issue_valid,
  output logic [3:0]                issue_op,
  output logic                      issue_itype,
  output logic [5:0]                issue_source_0_tag,
  output logic [5:0]                issue_source_1_tag,
  output logic [5:0]                issue_dest_tag,
  output logic [15:0]               issue_imm16,
  output logic [4:0]                issue_ROB_index,
  input  logic                      issue_ready,
  input  logic                      flush
);
  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam int IW = $clog2(RS_DEPTH);

  typedef struct packed {
    logic       needed;
    logic       ready;
    logic [5:0] tag;
  } src_t;

  typedef struct packed {
    logic [3:0]  op;
    logic        itype;
    src_t        src0;
    src_t        src1;
    logic [5:0]  dest;
    logic [15:0] imm16;
    logic [4:0]  rob;
  } rs_entry_t;

  rs_entry_t       ent   [RS_DEPTH];
  rs_entry_t       ent_w [RS_DEPTH+1];
  rs_entry_t       ent_n [RS_DEPTH];
  rs_entry_t       disp_w;
  logic [CW-1:0]   count, count_n, wr_idx;
  logic [IW-1:0]   sel_idx;
  logic            st_any, byp, st_fire, byp_fire, accept_wr;
  logic [43:0]     iss_bits;

  function automatic src_t wake_src(input src_t s, input logic [WAKEUP_PORTS-1:0] v,
                                    input logic [6*WAKEUP_PORTS-1:0] t);
    src_t r;
    r = s;
    for (int p = 0; p < WAKEUP_PORTS; p++)
      if (v[p] && s.needed && (s.tag == t[6*p +: 6])) r.ready = 1'b1;
    return r;
  endfunction

  function automatic rs_entry_t wake(input rs_entry_t e, input logic [WAKEUP_PORTS-1:0] v,
                                     input logic [6*WAKEUP_PORTS-1:0] t);
    rs_entry_t r;
    r      = e;
    r.src0 = wake_src(e.src0, v, t);
    r.src1 = wake_src(e.src1, v, t);
    return r;
  endfunction

  function automatic logic is_rdy(input rs_entry_t e);
    return (!e.src0.needed || e.src0.ready) && (!e.src1.needed || e.src1.ready);
  endfunction

  function automatic logic [43:0] pick(input rs_entry_t e);
    return {e.op, e.itype, e.src0.tag, e.src1.tag, e.dest, e.imm16, e.rob};
  endfunction

  assign disp_w = wake(rs_entry_t'(dispatch_struct), wakeup_valid, wakeup_tag);

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) ent_w[i] = wake(ent[i], wakeup_valid, wakeup_tag);
    ent_w[RS_DEPTH] = '0;
  end

  // Descending scan so the lowest (oldest) ready index wins.
  always_comb begin
    st_any  = 1'b0;
    sel_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if ((i < int'(count)) && is_rdy(ent[i])) begin
        st_any  = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign dispatch_ready = !RST && (int'(count) < RS_DEPTH);

`ifdef ALU_RS_BYPASS_EN
  assign byp = dispatch_valid && dispatch_ready && !flush && !st_any && is_rdy(disp_w);
`else
  assign byp = 1'b0;
`endif

  assign issue_valid = !RST && !flush && (st_any || byp);

  always_comb begin
    iss_bits = '0;
    if (issue_valid) iss_bits = st_any ? pick(ent[sel_idx]) : pick(disp_w);
  end

  assign {issue_op, issue_itype, issue_source_0_tag, issue_source_1_tag,
          issue_dest_tag, issue_imm16, issue_ROB_index} = iss_bits;

  // Collapse above the fired slot, then drop the (already woken) dispatch packet at the tail.
  always_comb begin
    st_fire   = issue_valid && issue_ready && st_any;
    byp_fire  = issue_valid && issue_ready && !st_any;
    accept_wr = dispatch_valid && dispatch_ready && !flush && !byp_fire;
    wr_idx    = count - CW'(st_fire);
    count_n   = count + CW'(accept_wr) - CW'(st_fire);
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_n[i] = (st_fire && (i >= int'(sel_idx))) ? ent_w[i+1] : ent_w[i];
      if (accept_wr && (i == int'(wr_idx))) ent_n[i] = disp_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count_n;
      for (int i = 0; i < RS_DEPTH; i++) ent[i] <= ent_n[i];
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: expected issues queued at dispatch, compared at fire.
module tb_alu_reservation_station;
  logic        CLK = 1'b0;
  logic        RST;
  logic        dispatch_valid;
  logic [47:0] dispatch_struct;
  logic        dispatch_ready;
  logic [2:0]  wakeup_valid;
  logic [17:0] wakeup_tag;
  logic        issue_valid;
  logic [3:0]  issue_op;
  logic        issue_itype;
  logic [5:0]  issue_source_0_tag;
  logic [5:0]  issue_source_1_tag;
  logic [5:0]  issue_dest_tag;
  logic [15:0] issue_imm16;
  logic [4:0]  issue_ROB_index;
  logic        issue_ready;
  logic        flush;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [43:0] sb [$];
  logic [43:0] last_rec;
  logic [43:0] rec_a;

  alu_reservation_station #(.RS_DEPTH(4), .WAKEUP_PORTS(3)) dut (
    .CLK(CLK), .RST(RST),
    .dispatch_valid(dispatch_valid), .dispatch_struct(dispatch_struct), .dispatch_ready(dispatch_ready),
    .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_itype(issue_itype),
    .issue_source_0_tag(issue_source_0_tag), .issue_source_1_tag(issue_source_1_tag),
    .issue_dest_tag(issue_dest_tag), .issue_imm16(issue_imm16), .issue_ROB_index(issue_ROB_index),
    .issue_ready(issue_ready), .flush(flush)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic itype,
                       input logic n0, input logic r0, input logic [5:0] t0,
                       input logic n1, input logic r1, input logic [5:0] t1,
                       input logic [5:0] dest, input logic [15:0] imm, input logic [4:0] rob);
    dispatch_valid  = 1'b1;
    dispatch_struct = {op, itype, n0, r0, t0, n1, r1, t1, dest, imm, rob};
    last_rec        = {op, itype, t0, t1, dest, imm, rob};
  endtask

  // Every fire pops the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && issue_valid && issue_ready) begin
      if (sb.size() == 0) check("unexpected_issue", 64'(issue_ROB_index), 64'h1f_dead);
      else check("issue_bundle",
                 64'({issue_op, issue_itype, issue_source_0_tag, issue_source_1_tag,
                      issue_dest_tag, issue_imm16, issue_ROB_index}),
                 64'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; dispatch_valid = 1'b0; dispatch_struct = '0;
    wakeup_valid = '0; wakeup_tag = '0; issue_ready = 1'b0; flush = 1'b0;
    step(); step();
    check("rst_dispatch_ready", 64'(dispatch_ready), 0);
    check("rst_issue_valid", 64'(issue_valid), 0);
    check("rst_issue_fields", 64'({issue_op, issue_itype, issue_source_0_tag, issue_source_1_tag,
                                   issue_dest_tag, issue_imm16, issue_ROB_index}), 0);
    RST = 1'b0;
    #1;
    check("post_rst_dispatch_ready", 64'(dispatch_ready), 1);

    // Single ADD, no sources needed: issues the cycle after accept.
    issue_ready = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 1'b0, 6'd3, 1'b0, 1'b0, 6'd4, 6'd40, 16'h1234, 5'd0);
    sb.push_back(last_rec);
    #1;
    check("t1_no_issue_same_cycle", 64'(issue_valid), 0);
    step();
    dispatch_valid = 1'b0;
    check("t1_issue_valid_n1", 64'(issue_valid), 1);
    step();
    check("t1_empty_after", 64'(issue_valid), 0);
    check("t1_dispatch_ready", 64'(dispatch_ready), 1);

    // Fill four entries waiting on tag 10, then wake them all.
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(4'h1, 1'(k), 1'b1, 1'b0, 6'd10, 1'b0, 1'b0, 6'd0, 6'(20 + k), 16'(k * 3), 5'(k));
      sb.push_back(last_rec);
      step();
    end
    dispatch_valid = 1'b0;
    check("t2_full_dispatch_ready", 64'(dispatch_ready), 0);
    check("t2_full_no_issue", 64'(issue_valid), 0);
    wakeup_valid = 3'b001; wakeup_tag = {12'd0, 6'd10}; issue_ready = 1'b1;
    step();
    wakeup_valid = '0; wakeup_tag = '0;
    check("t2_woken_issue_valid", 64'(issue_valid), 1);
    check("t2_first_rob", 64'(issue_ROB_index), 0);
    step();
    check("t2_ready_after_fire", 64'(dispatch_ready), 1);
    step(); step(); step();
    check("t2_drained", 64'(issue_valid), 0);

    // Older entry waits on tag 5, younger ready entry issues first.
    issue_ready = 1'b0;
    drive(4'h2, 1'b0, 1'b1, 1'b0, 6'd5, 1'b0, 1'b0, 6'd1, 6'd50, 16'hAAAA, 5'd4);
    rec_a = last_rec;
    step();
    drive(4'h3, 1'b1, 1'b0, 1'b0, 6'd2, 1'b1, 1'b1, 6'd8, 6'd51, 16'h5555, 5'd5);
    sb.push_back(last_rec);
    sb.push_back(rec_a);
    step();
    dispatch_valid = 1'b0;
    check("t3_younger_valid", 64'(issue_valid), 1);
    check("t3_younger_rob", 64'(issue_ROB_index), 5);
    issue_ready = 1'b1;
    step();
    wakeup_valid = 3'b010; wakeup_tag = {6'd0, 6'd5, 6'd0};
    check("t3_older_still_waiting", 64'(issue_valid), 0);
    step();
    wakeup_valid = '0; wakeup_tag = '0;
    check("t3_older_valid", 64'(issue_valid), 1);
    check("t3_older_rob", 64'(issue_ROB_index), 4);
    step();
    check("t3_empty", 64'(issue_valid), 0);

    // Wakeup gating: invalid port or other tag must not wake.
    drive(4'h4, 1'b0, 1'b1, 1'b0, 6'd9, 1'b0, 1'b0, 6'd12, 6'd52, 16'h0F0F, 5'd8);
    sb.push_back(last_rec);
    step();
    dispatch_valid = 1'b0;
    wakeup_valid = 3'b000; wakeup_tag = {12'd0, 6'd9};
    step();
    check("t3b_invalid_port_no_wake", 64'(issue_valid), 0);
    wakeup_valid = 3'b001; wakeup_tag = {12'd0, 6'd12};
    step();
    check("t3b_other_tag_no_wake", 64'(issue_valid), 0);
    wakeup_valid = 3'b001; wakeup_tag = {12'd0, 6'd9};
    step();
    wakeup_valid = '0; wakeup_tag = '0;
    check("t3b_woken", 64'(issue_valid), 1);
    step();

    // Same-cycle wakeup of the dispatch packet on port 2.
    drive(4'h5, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd7, 6'd53, 16'hC0DE, 5'd6);
    sb.push_back(last_rec);
    wakeup_valid = 3'b100; wakeup_tag = {6'd7, 12'd0};
    step();
    dispatch_valid = 1'b0; wakeup_valid = '0; wakeup_tag = '0;
    check("t4_dispatch_wake_valid", 64'(issue_valid), 1);
    check("t4_dispatch_wake_rob", 64'(issue_ROB_index), 6);
    step();
    check("t4_empty", 64'(issue_valid), 0);

    // Hold under backpressure for three cycles, then exactly one fire.
    issue_ready = 1'b0;
    drive(4'h6, 1'b0, 1'b0, 1'b0, 6'd11, 1'b0, 1'b0, 6'd12, 6'd33, 16'hBEEF, 5'd9);
    sb.push_back(last_rec);
    step();
    dispatch_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t5_hold_valid", 64'(issue_valid), 1);
      check("t5_hold_rob", 64'(issue_ROB_index), 9);
      check("t5_hold_imm", 64'(issue_imm16), 64'hBEEF);
      step();
    end
    issue_ready = 1'b1;
    step();
    check("t5_single_fire", 64'(issue_valid), 0);

    // Flush with simultaneous dispatch and a would-be fire.
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(4'h7, 1'b0, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0, 6'd2, 6'(60 + k), 16'(k), 5'(11 + k));
      step();
    end
    dispatch_valid = 1'b0;
    check("t6_pre_flush_valid", 64'(issue_valid), 1);
    flush = 1'b1; issue_ready = 1'b1;
    drive(4'h8, 1'b0, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0, 6'd2, 6'd63, 16'hFFFF, 5'd14);
    #1;
    check("t6_flush_cycle_no_issue", 64'(issue_valid), 0);
    step();
    flush = 1'b0; dispatch_valid = 1'b0;
    check("t6_after_flush_valid", 64'(issue_valid), 0);
    check("t6_after_flush_ready", 64'(dispatch_ready), 1);
    step();
    check("t6_flush_dispatch_dropped", 64'(issue_valid), 0);

    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
